pipe_hazard_ctrl: RTL and testbench

Central hazard and stall controller for the 5-stage PipeLine datapath (IF/ID/EX/MEM/WB).
- Detects load-use hazards, taken-branch flushes and multi-cycle data-memory waits.
- Drives the PC and pipeline-register write-enable/flush controls and the EX-stage forwarding muxes.
- Keeps saturating stall/flush counters and a sticky memory-timeout flag for debug.

---
 rtl/pipe_hazard_ctrl.sv | 92 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use/branch/memory-wait hazard control, forwarding and debug counters
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [4:0]       ex_rs,
   input  logic [4:0]       ex_rt,
   input  logic [4:0]       ex_rwd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic [4:0]       mem_rwd,
   input  logic             mem_reg_write,
   input  logic [4:0]       wb_rwd,
   input  logic             wb_reg_write,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             pc_sel_branch,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_we,
   output logic             idex_flush,
   output logic             exmem_we,
   output logic             memwb_we,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   typedef enum logic {RUN, MEM_WAIT} state_t;
   state_t state;
   logic [WW-1:0] wait_cnt;
   logic timeout, completing, freeze, branch, load_use, run;
   assign timeout    = state == MEM_WAIT && wait_cnt == WW'(MEM_TIMEOUT);
   assign completing = state == MEM_WAIT && (mem_ready || timeout);
   assign freeze     = (state == MEM_WAIT && !completing) || (state == RUN && mem_req && !mem_ready);
   assign branch     = !freeze && ex_branch_taken;
   assign load_use   = !freeze && !ex_branch_taken && ex_mem_read && ex_rwd != 5'd0 &&
                       ((id_use_rs && id_rs == ex_rwd) || (id_use_rt && id_rt == ex_rwd));
   assign run        = !rst && !freeze;
   // Pipeline enables and flushes; reset forces every stage to hold and load bubbles
   always_comb begin
      pc_we         = run && !load_use;
      pc_sel_branch = !rst && branch;
      ifid_we       = run && !load_use;
      ifid_flush    = rst || branch;
      idex_we       = run;
      idex_flush    = rst || branch || load_use;
      exmem_we      = run;
      memwb_we      = run;
   end
   // EX operand forwarding, youngest producer (MEM) first, register 0 never forwarded
   always_comb begin
      fwd_a = rst ? 2'b00 :
              (mem_reg_write && mem_rwd != 5'd0 && mem_rwd == ex_rs) ? 2'b01 :
              (wb_reg_write && wb_rwd != 5'd0 && wb_rwd == ex_rs) ? 2'b10 : 2'b00;
      fwd_b = rst ? 2'b00 :
              (mem_reg_write && mem_rwd != 5'd0 && mem_rwd == ex_rt) ? 2'b01 :
              (wb_reg_write && wb_rwd != 5'd0 && wb_rwd == ex_rt) ? 2'b10 : 2'b00;
   end
   // Memory-wait FSM with timeout abort, sticky error flag and saturating counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         wait_cnt  <= '0;
         mem_err   <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (state == RUN && freeze) begin
            state    <= MEM_WAIT;
            wait_cnt <= WW'(1);
         end else if (completing) begin
            state    <= RUN;
            wait_cnt <= '0;
         end else if (state == MEM_WAIT) begin
            wait_cnt <= wait_cnt + WW'(1);
         end
         if (timeout && !mem_ready) mem_err <= 1'b1;
         if ((freeze || load_use) && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (branch && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: random stimulus, reference model and scoreboard for the hazard controller
module tb_pipe_hazard_ctrl;
   localparam int TO = 4;
   localparam int CW = 4;
   localparam int SAT = (1 << CW) - 1;
   logic clk = 1'b0, rst = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rs = '0, ex_rt = '0, ex_rwd = '0, mem_rwd = '0, wb_rwd = '0;
   logic id_use_rs = 0, id_use_rt = 0, ex_mem_read = 0, ex_branch_taken = 0;
   logic mem_reg_write = 0, wb_reg_write = 0, mem_req = 0, mem_ready = 0;
   logic pc_we, pc_sel_branch, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we, mem_err;
   logic [1:0] fwd_a, fwd_b;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [20:0] act;
   logic [20:0] exp_q[$];
   int checks = 0, errors = 0, cyc = 0;
   int waited = 0, scnt = 0, fcnt = 0;
   bit merr = 0;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rwd(ex_rwd), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .mem_rwd(mem_rwd), .mem_reg_write(mem_reg_write),
      .wb_rwd(wb_rwd), .wb_reg_write(wb_reg_write), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_we(pc_we), .pc_sel_branch(pc_sel_branch), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
      .idex_we(idex_we), .idex_flush(idex_flush), .exmem_we(exmem_we), .memwb_we(memwb_we),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   assign act = {pc_we, pc_sel_branch, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we,
                 fwd_a, fwd_b, mem_err, stall_cnt, flush_cnt};

   function automatic logic [1:0] fwd(input logic [4:0] src);
      if (mem_reg_write && mem_rwd != 0 && mem_rwd == src) return 2'b01;
      if (wb_reg_write && wb_rwd != 0 && wb_rwd == src) return 2'b10;
      return 2'b00;
   endfunction

   task automatic cycle(input int rst_pct, input int req_pct, input int ready_pct, input bit force_rst);
      bit comp, frz, br, lu, run;
      @(posedge clk);
      #1;
      rst             = force_rst || ($urandom_range(99) < rst_pct);
      id_rs           = 5'($urandom_range(3));
      id_rt           = 5'($urandom_range(3));
      ex_rs           = 5'($urandom_range(3));
      ex_rt           = 5'($urandom_range(3));
      ex_rwd          = 5'($urandom_range(3));
      mem_rwd         = 5'($urandom_range(3));
      wb_rwd          = 5'($urandom_range(3));
      id_use_rs       = 1'($urandom_range(1));
      id_use_rt       = 1'($urandom_range(1));
      ex_mem_read     = 1'($urandom_range(1));
      ex_branch_taken = $urandom_range(99) < 20;
      mem_reg_write   = 1'($urandom_range(1));
      wb_reg_write    = 1'($urandom_range(1));
      mem_req         = $urandom_range(99) < req_pct;
      mem_ready       = $urandom_range(99) < ready_pct;
      comp = waited > 0 && (mem_ready || waited >= TO);
      frz  = (waited > 0 && !comp) || (waited == 0 && mem_req && !mem_ready);
      br   = !frz && ex_branch_taken;
      lu   = !frz && !br && ex_mem_read && ex_rwd != 0 &&
             ((id_use_rs && id_rs == ex_rwd) || (id_use_rt && id_rt == ex_rwd));
      run  = !frz;
      if (rst) exp_q.push_back({8'b0001_0100, 4'b0000, merr, CW'(scnt), CW'(fcnt)});
      else exp_q.push_back({run && !lu, br, run && !lu, br, run, br || lu, run, run,
                            fwd(ex_rs), fwd(ex_rt), merr, CW'(scnt), CW'(fcnt)});
      if (rst) begin
         waited = 0; scnt = 0; fcnt = 0; merr = 0;
      end else begin
         if (frz || lu) scnt = (scnt < SAT) ? scnt + 1 : SAT;
         if (br) fcnt = (fcnt < SAT) ? fcnt + 1 : SAT;
         if (waited >= TO && !mem_ready) merr = 1;
         waited = comp ? 0 : frz ? waited + 1 : 0;
      end
   endtask

   // Scoreboard: every cycle with a pending expectation is compared mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [20:0] e;
         e = exp_q.pop_front();
         checks++;
         cyc++;
         if (act !== e) begin
            errors++;
            $display("FAIL ctrl cycle %0d act=%b exp=%b", cyc, act, e);
         end
      end
   end

   initial begin
      @(posedge clk);
      cycle(0, 0, 100, 1);
      for (int i = 0; i < 1500; i++) cycle(2, 30, 60, 0);
      for (int i = 0; i < 1500; i++) cycle(1, 50, 5, 0);
      for (int i = 0; i < 1500; i++) cycle(0, 40, 40, 0);
      cycle(0, 0, 100, 1);
      for (int i = 0; i < 500; i++) cycle(0, 60, 0, 0);
      @(posedge clk);
      @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain act=%0d exp=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
